// File: rtl/washer_pkg.sv
// Shared definitions for the washer controller and its phase timer:
// the phase encoding (aligned with the controller's 3-bit state code)
// and the default phase limits.
package washer_pkg;

  // Phase encoding reuses the controller's 3-bit state code. The
  // controller's START (0) and READY (1) states both mean "no timed
  // operation active", so the timer folds them into PH_IDLE.
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd2,
    PH_HEAT  = 3'd3,
    PH_WASH  = 3'd4,
    PH_RINSE = 3'd5,
    PH_SPIN  = 3'd6
  } phase_e;

  // Controller codes that have no timed counterpart here.
  localparam logic [2:0] CTRL_START = 3'd0;
  localparam logic [2:0] CTRL_READY = 3'd1;

  // Default limits, in clock cycles.
  localparam int DEF_FILL_TIMEOUT = 500;
  localparam int DEF_HEAT_TIMEOUT = 800;
  localparam int DEF_WASH_CYCLES  = 300;
  localparam int DEF_RINSE_CYCLES = 200;
  localparam int DEF_SPIN_CYCLES  = 150;
  localparam int DEF_CNT_W        = 16;

  // Fill and heat are supervised phases: reaching the limit is a fault
  // (time-out) rather than a normal completion.
  function automatic logic is_supervised(input phase_e p);
    return (p == PH_FILL) || (p == PH_HEAT);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Saturating phase-duration counter. clr forces zero (no phase), load
// starts a new phase at 1, hold freezes the count, otherwise the count
// climbs by one until it reaches limit and then stays there.
// hit flags the cycle whose update lands the count exactly on limit.
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             hold_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             hit_d;

  // Next count and limit-reached flag; priority clr > load > hold > count.
  always_comb begin
    count_d = count_q;
    hit_d   = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = CNT_W'(1);
      hit_d   = (limit_i == CNT_W'(1));
    end else if (!hold_i && (count_q < limit_i)) begin
      // Guarded by count_q < limit_i, so the increment can never wrap.
      count_d = count_q + CNT_W'(1);
      hit_d   = (count_q == (limit_i - CNT_W'(1)));
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign hit_o   = hit_d;

endmodule

// File: rtl/wash_phase_timer.sv
// Per-phase timing and supervision for the washing-machine controller.
// Decodes the controller's one-hot operation outputs into a phase,
// times each phase and raises time-out / completion levels that the
// controller consumes. Every output comes directly from a flop.
//
// Handshake: none. Inputs are sampled as levels on every rising clock
// edge; outputs are registered levels that stay high until the phase
// changes or reset asserts, so a slower consumer cannot miss them.
module wash_phase_timer
  import washer_pkg::*;
#(
  parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
  parameter int HEAT_TIMEOUT = DEF_HEAT_TIMEOUT,
  parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int RINSE_CYCLES = DEF_RINSE_CYCLES,
  parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fill_Water_Operation,
  input  logic             heat_Water_Operation,
  input  logic             wash_Operation,
  input  logic             rinse_Operation,
  input  logic             spin_Operation,
  input  logic             sig_Full,
  input  logic             sig_Temperature,
  output logic             sig_Time_Out,
  output logic             sig_Wash_Completed,
  output logic             sig_Rinse_Completed,
  output logic             sig_Spin_Completed,
  output logic             phase_Error,
  output logic [CNT_W-1:0] elapsed,
  output logic [2:0]       dbg_phase
);

  localparam logic [CNT_W-1:0] LIM_FILL  = CNT_W'(FILL_TIMEOUT);
  localparam logic [CNT_W-1:0] LIM_HEAT  = CNT_W'(HEAT_TIMEOUT);
  localparam logic [CNT_W-1:0] LIM_WASH  = CNT_W'(WASH_CYCLES);
  localparam logic [CNT_W-1:0] LIM_RINSE = CNT_W'(RINSE_CYCLES);
  localparam logic [CNT_W-1:0] LIM_SPIN  = CNT_W'(SPIN_CYCLES);

  logic [4:0]       ops;
  phase_e           dec_phase;
  logic             multi_hot;
  logic             entry;
  logic             frozen;
  logic [CNT_W-1:0] limit_sel;
  logic             cnt_hit;

  phase_e phase_q,     phase_d;
  logic   time_out_q,  time_out_d;
  logic   wash_done_q, wash_done_d;
  logic   rinse_done_q, rinse_done_d;
  logic   spin_done_q, spin_done_d;
  logic   phase_err_q, phase_err_d;

  assign ops = {fill_Water_Operation, heat_Water_Operation, wash_Operation,
                rinse_Operation, spin_Operation};

  // Decode the single active operation; zero or several active means IDLE.
  always_comb begin
    dec_phase = PH_IDLE;
    case (ops)
      5'b10000: dec_phase = PH_FILL;
      5'b01000: dec_phase = PH_HEAT;
      5'b00100: dec_phase = PH_WASH;
      5'b00010: dec_phase = PH_RINSE;
      5'b00001: dec_phase = PH_SPIN;
      default:  dec_phase = PH_IDLE;
    endcase
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_hot = (ops & (ops - 5'd1)) != 5'd0;

  // A change of decoded phase restarts timing and drops stale status.
  assign entry = (dec_phase != phase_q);

  // A satisfied sensor suspends supervision of fill/heat.
  assign frozen = ((dec_phase == PH_FILL) && sig_Full) ||
                  ((dec_phase == PH_HEAT) && sig_Temperature);

  // Limit for the phase being counted this cycle; on a stay the decoded
  // and registered phases agree, so the decoded one serves both cases.
  always_comb begin
    limit_sel = '0;
    case (dec_phase)
      PH_FILL:  limit_sel = LIM_FILL;
      PH_HEAT:  limit_sel = LIM_HEAT;
      PH_WASH:  limit_sel = LIM_WASH;
      PH_RINSE: limit_sel = LIM_RINSE;
      PH_SPIN:  limit_sel = LIM_SPIN;
      default:  limit_sel = '0;
    endcase
  end

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (dec_phase == PH_IDLE),
    .load_i  (entry),
    .hold_i  (frozen),
    .limit_i (limit_sel),
    .count_o (elapsed),
    .hit_o   (cnt_hit)
  );

  // Phase FSM next state plus status next values; defaults hold state.
  always_comb begin
    phase_d      = dec_phase;
    phase_err_d  = multi_hot;
    time_out_d   = time_out_q;
    wash_done_d  = wash_done_q;
    rinse_done_d = rinse_done_q;
    spin_done_d  = spin_done_q;

    if (dec_phase == PH_IDLE || entry) begin
      time_out_d   = 1'b0;
      wash_done_d  = 1'b0;
      rinse_done_d = 1'b0;
      spin_done_d  = 1'b0;
    end

    // The sensor wins over a limit reached on the same edge.
    if (cnt_hit && !frozen) begin
      if (is_supervised(dec_phase)) begin
        time_out_d = 1'b1;
      end else begin
        case (dec_phase)
          PH_WASH:  wash_done_d  = 1'b1;
          PH_RINSE: rinse_done_d = 1'b1;
          PH_SPIN:  spin_done_d  = 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // Phase state and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q      <= PH_IDLE;
      phase_err_q  <= 1'b0;
      time_out_q   <= 1'b0;
      wash_done_q  <= 1'b0;
      rinse_done_q <= 1'b0;
      spin_done_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      phase_err_q  <= phase_err_d;
      time_out_q   <= time_out_d;
      wash_done_q  <= wash_done_d;
      rinse_done_q <= rinse_done_d;
      spin_done_q  <= spin_done_d;
    end
  end

  assign sig_Time_Out        = time_out_q;
  assign sig_Wash_Completed  = wash_done_q;
  assign sig_Rinse_Completed = rinse_done_q;
  assign sig_Spin_Completed  = spin_done_q;
  assign phase_Error         = phase_err_q;
  assign dbg_phase           = phase_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer with short phase limits.
module tb_wash_phase_timer;
  import washer_pkg::*;

  localparam int W_C = 4, R_C = 3, S_C = 2, F_T = 5, H_T = 6;
  localparam int OBS_W = 24;

  localparam logic [4:0] OP_IDLE  = 5'b00000;
  localparam logic [4:0] OP_FILL  = 5'b10000;
  localparam logic [4:0] OP_HEAT  = 5'b01000;
  localparam logic [4:0] OP_WASH  = 5'b00100;
  localparam logic [4:0] OP_RINSE = 5'b00010;
  localparam logic [4:0] OP_SPIN  = 5'b00001;

  logic clock, reset;
  logic fill_op, heat_op, wash_op, rinse_op, spin_op, full, temp;
  logic time_out, wash_done, rinse_done, spin_done, perr;
  logic [15:0] elapsed;
  logic [2:0]  dbg_phase;

  int n_checks = 0;
  int n_pass   = 0;

  logic [OBS_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  wash_phase_timer #(
    .FILL_TIMEOUT (F_T), .HEAT_TIMEOUT (H_T), .WASH_CYCLES (W_C),
    .RINSE_CYCLES (R_C), .SPIN_CYCLES  (S_C), .CNT_W       (16)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .fill_Water_Operation (fill_op),
    .heat_Water_Operation (heat_op),
    .wash_Operation       (wash_op),
    .rinse_Operation      (rinse_op),
    .spin_Operation       (spin_op),
    .sig_Full             (full),
    .sig_Temperature      (temp),
    .sig_Time_Out         (time_out),
    .sig_Wash_Completed   (wash_done),
    .sig_Rinse_Completed  (rinse_done),
    .sig_Spin_Completed   (spin_done),
    .phase_Error          (perr),
    .elapsed              (elapsed),
    .dbg_phase            (dbg_phase)
  );

  // ---------------- reference model ----------------
  // Phase index: 0 idle, 1 fill, 2 heat, 3 wash, 4 rinse, 5 spin.
  int   lim_tbl[6] = '{0, F_T, H_T, W_C, R_C, S_C};
  int   m_phase, m_el;
  logic m_err;
  logic m_flag[6];  // status per phase index (1,2 share time-out)

  function automatic logic [2:0] ph_code(input int p);
    case (p)
      1: return PH_FILL;
      2: return PH_HEAT;
      3: return PH_WASH;
      4: return PH_RINSE;
      5: return PH_SPIN;
      default: return PH_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_el = 0; m_err = 1'b0;
    for (int i = 0; i < 6; i++) m_flag[i] = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] ops, input logic f, input logic t);
    int ph;
    logic frz, reached;
    ph = 0;
    if ($countones(ops) == 1)
      for (int b = 0; b < 5; b++) if (ops[4-b]) ph = b + 1;
    m_err = ($countones(ops) > 1);
    frz = (ph == 1 && f) || (ph == 2 && t);
    reached = 1'b0;
    if (ph == 0) begin
      m_el = 0;
      for (int i = 0; i < 6; i++) m_flag[i] = 1'b0;
    end else if (ph != m_phase) begin
      m_el = 1;
      for (int i = 0; i < 6; i++) m_flag[i] = 1'b0;
      reached = (lim_tbl[ph] == 1) && !frz;
    end else if (!frz && m_el < lim_tbl[ph]) begin
      m_el++;
      reached = (m_el == lim_tbl[ph]);
    end
    if (reached) m_flag[ph] = 1'b1;
    m_phase = ph;
  endtask

  function automatic logic [OBS_W-1:0] model_obs();
    return {m_err, m_flag[1] | m_flag[2], m_flag[3], m_flag[4], m_flag[5],
            16'(m_el), ph_code(m_phase)};
  endfunction

  function automatic logic [OBS_W-1:0] dut_obs();
    return {perr, time_out, wash_done, rinse_done, spin_done, elapsed, dbg_phase};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Drives inputs now (between edges), lets one rising edge pass,
  // then compares the DUT against the model's expectation.
  task automatic step(input logic [4:0] ops, input logic f, input logic t);
    {fill_op, heat_op, wash_op, rinse_op, spin_op} = ops;
    full = f;
    temp = t;
    @(posedge clock);
    model_step(ops, f, t);
    exp_q.push_back(model_obs());
    #1;
    check("model", 32'(dut_obs()), 32'(exp_q.pop_front()));
  endtask

  // Reset pulse in the middle of a cycle; outputs must clear before any edge.
  task automatic mid_reset(input string nm);
    #2 reset = 1'b1;
    #1 check(nm, 32'(dut_obs()), 32'd0);
    model_reset();
    #2 reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  ops;
    logic        f;
    logic        t;
    logic [15:0] el;
    logic [3:0]  st;   // {time_out, wash, rinse, spin}
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] o, input logic f, input logic t,
                              input int el, input logic [3:0] st, input logic err);
    vec_t v;
    v.ops = o; v.f = f; v.t = t; v.el = 16'(el); v.st = st; v.err = err;
    return v;
  endfunction

  // Controller model for the chained sequence: holds a phase until its
  // completion output rises, bounded by a cycle budget.
  task automatic run_phase(input logic [4:0] ops, input int want, input string nm);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      step(ops, 1'b0, 1'b0);
      n++;
      case (ops)
        OP_WASH:  done = wash_done;
        OP_RINSE: done = rinse_done;
        default:  done = spin_done;
      endcase
    end
    check(nm, 32'(n), 32'(want));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [4:0] cur_ops;
    logic [4:0] sel;

    // wash completion and hold, then chain and cancel
    tbl.push_back(mk(OP_IDLE,  0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(OP_WASH,  0, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(OP_WASH,  0, 0, 2, 4'b0000, 0));
    tbl.push_back(mk(OP_WASH,  0, 0, 3, 4'b0000, 0));
    tbl.push_back(mk(OP_WASH,  0, 0, 4, 4'b0100, 0));
    tbl.push_back(mk(OP_WASH,  0, 0, 4, 4'b0100, 0));
    tbl.push_back(mk(OP_RINSE, 0, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(OP_RINSE, 0, 0, 2, 4'b0000, 0));
    tbl.push_back(mk(OP_RINSE, 0, 0, 3, 4'b0010, 0));
    tbl.push_back(mk(OP_SPIN,  0, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(OP_SPIN,  0, 0, 2, 4'b0001, 0));
    tbl.push_back(mk(OP_IDLE,  0, 0, 0, 4'b0000, 0));
    // fill time-out, then a sensor that arrives after the limit
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(OP_FILL, 0, 0, i, (i == 5) ? 4'b1000 : 4'b0000, 0));
    tbl.push_back(mk(OP_FILL,  1, 0, 5, 4'b1000, 0));
    tbl.push_back(mk(OP_IDLE,  0, 0, 0, 4'b0000, 0));
    // fill with the tank full from the 5th edge: freeze at 4, no time-out
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(OP_FILL, 0, 0, i, 4'b0000, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(OP_FILL, 1, 0, 4, 4'b0000, 0));
    tbl.push_back(mk(OP_IDLE,  0, 0, 0, 4'b0000, 0));
    // heat time-out, and sensor held at the limit edge
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(OP_HEAT, 0, 0, i, 4'b0000, 0));
    tbl.push_back(mk(OP_HEAT,  0, 1, 5, 4'b0000, 0));
    tbl.push_back(mk(OP_HEAT,  0, 0, 6, 4'b1000, 0));
    // phase error and restart
    tbl.push_back(mk(OP_WASH,  0, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(OP_WASH | OP_RINSE, 0, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(OP_WASH,  0, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(OP_WASH,  0, 0, 2, 4'b0000, 0));

    {fill_op, heat_op, wash_op, rinse_op, spin_op, full, temp} = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 check("reset_state", 32'(dut_obs()), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].ops, tbl[i].f, tbl[i].t);
      check($sformatf("vec%0d", i),
            {27'd0, perr, time_out, wash_done, rinse_done, spin_done},
            {27'd0, tbl[i].err, tbl[i].st});
      check($sformatf("vec%0d_elapsed", i), 32'(elapsed), 32'(tbl[i].el));
    end

    // reset mid-rinse at elapsed = 2, then a fresh rinse after release
    step(OP_RINSE, 0, 0);
    step(OP_RINSE, 0, 0);
    check("rinse_pre_reset", 32'(elapsed), 32'd2);
    mid_reset("async_reset");
    step(OP_RINSE, 0, 0);
    step(OP_RINSE, 0, 0);
    check("rinse_not_yet", 32'(rinse_done), 32'd0);
    step(OP_RINSE, 0, 0);
    check("rinse_after_reset", 32'(rinse_done), 32'd1);

    // controller-driven chain; each phase entered back-to-back
    step(OP_IDLE, 0, 0);
    run_phase(OP_WASH,  W_C, "chain_wash_edges");
    run_phase(OP_RINSE, R_C, "chain_rinse_edges");
    check("chain_wash_cleared", 32'(wash_done), 32'd0);
    run_phase(OP_SPIN,  S_C, "chain_spin_edges");
    // cancel while spin completed
    step(OP_IDLE, 0, 0);
    check("cancel", {15'd0, spin_done, elapsed}, 32'd0);

    // randomized runs against the model
    mid_reset("rand_reset");
    cur_ops = OP_IDLE;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = 5'($urandom_range(0, 7));
        if (sel == 0)      cur_ops = OP_IDLE;
        else if (sel <= 5) cur_ops = 5'b00001 << (5 - sel);
        else               cur_ops = 5'($urandom_range(0, 31));
      end
      step(cur_ops, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
